sensor_alarm_hub: RTL



---
 rtl/sensor_alarm_hub.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sensor_alarm_hub.sv
// N-channel on/off sensor monitor: synchronise, polarity-normalise and debounce each pin,
// drive level or latched alarms, count alarm events and report them over a round-robin event port.
module sensor_alarm_hub #(
  parameter int                CH_NUM       = 4,
  parameter int                DEB_CYCLES   = 500000,
  parameter int                CNT_W        = 8,
  parameter logic [CH_NUM-1:0] ACT_LOW_MASK = {CH_NUM{1'b1}},
  parameter logic [CH_NUM-1:0] LATCH_MASK   = {CH_NUM{1'b0}},
  localparam int               CH_W         = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_NUM-1:0] sensor_in,
  input  logic [CH_NUM-1:0] clr,
  output logic [CH_NUM-1:0] alarm,
  output logic              alarm_any,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [CH_W-1:0]   evt_ch,
  input  logic [CH_W-1:0]   cnt_sel,
  output logic [CNT_W-1:0]  cnt_out
);

  localparam int                DCNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [CH_NUM-1:0] sync1_q, sync1_d;
  logic [CH_NUM-1:0] sync2_q, sync2_d;
  logic [CH_NUM-1:0] act;
  logic [CH_NUM-1:0] deb_q, deb_d;
  logic [CH_NUM-1:0] deb_dly_q, deb_dly_d;
  logic [DCNT_W-1:0] dcnt_q [CH_NUM];
  logic [DCNT_W-1:0] dcnt_d [CH_NUM];
  logic [CH_NUM-1:0] rise;
  logic [CH_NUM-1:0] alarm_q, alarm_d;
  logic [CNT_W-1:0]  cnt_q [CH_NUM];
  logic [CNT_W-1:0]  cnt_d [CH_NUM];
  logic [CNT_W-1:0]  cnt_out_q, cnt_out_d;
  logic [CH_NUM-1:0] pending_q, pending_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   grant;
  logic [CH_W-1:0]   idx;
  logic              grant_vld;
  logic              load;

  assign sync1_d   = sensor_in;
  assign sync2_d   = sync1_q;
  assign act       = sync2_q ^ ACT_LOW_MASK;
  assign deb_dly_d = deb_q;
  assign rise      = deb_q & ~deb_dly_q;

  // A new level is accepted only after DEB_CYCLES consecutive samples disagree with the held one.
  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      deb_d[i]  = deb_q[i];
      dcnt_d[i] = '0;
      if (act[i] != deb_q[i]) begin
        if (dcnt_q[i] == DEB_LAST) begin
          deb_d[i] = ~deb_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      if (LATCH_MASK[i]) begin
        alarm_d[i] = alarm_q[i];
        if (rise[i]) begin
          alarm_d[i] = 1'b1;
        end else if (clr[i] && !deb_q[i]) begin
          alarm_d[i] = 1'b0;
        end
      end else begin
        alarm_d[i] = deb_q[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
      end else if (rise[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cnt_out_d = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (cnt_sel == CH_W'(i)) begin
        cnt_out_d = cnt_q[i];
      end
    end
  end

  // Round-robin: first pending channel strictly after the last granted one, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = 1; k <= CH_NUM; k++) begin
      idx = CH_W'((int'(ptr_q) + k) % CH_NUM);
      if (!grant_vld && pending_q[idx]) begin
        grant_vld = 1'b1;
        grant     = idx;
      end
    end
  end

  // Event port handshake: a record transfers on a clock edge where evt_valid && evt_ready;
  // while evt_valid is high and evt_ready low, evt_valid and evt_ch hold unchanged.
  always_comb begin
    load        = (!evt_valid_q || evt_ready) && grant_vld;
    pending_d   = pending_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    ptr_d       = ptr_q;
    if (load) begin
      evt_valid_d      = 1'b1;
      evt_ch_d         = grant;
      ptr_d            = grant;
      pending_d[grant] = 1'b0;
    end else if (evt_ready) begin
      evt_valid_d = 1'b0;
    end
    pending_d = pending_d | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= ACT_LOW_MASK;
      sync2_q     <= ACT_LOW_MASK;
      deb_q       <= '0;
      deb_dly_q   <= '0;
      alarm_q     <= '0;
      cnt_out_q   <= '0;
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      ptr_q       <= CH_W'(CH_NUM - 1);
      for (int i = 0; i < CH_NUM; i++) begin
        dcnt_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      deb_q       <= deb_d;
      deb_dly_q   <= deb_dly_d;
      alarm_q     <= alarm_d;
      cnt_out_q   <= cnt_out_d;
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      ptr_q       <= ptr_d;
      dcnt_q      <= dcnt_d;
      cnt_q       <= cnt_d;
    end
  end

  assign alarm     = alarm_q;
  assign alarm_any = |alarm_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign cnt_out   = cnt_out_q;

endmodule
